// File: rtl/id_serial_issue_if.sv
// Handshake bundle between decode (ID), the issue register and EXE.
// slave  : the issue register's view (accepts from ID, drives the EXE slot).
// master : the surrounding pipeline's view (decode drives, EXE consumes).
interface id_serial_issue_if #(
  parameter int PAYLOAD_W = 160
);
  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 in_serialize;
  logic                 in_notify;
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 out_marker;

  modport slave (
    input  in_valid, in_payload, in_serialize, in_notify, out_ready,
    output in_ready, out_valid, out_payload, out_marker
  );

  modport master (
    output in_valid, in_payload, in_serialize, in_notify, out_ready,
    input  in_ready, out_valid, out_payload, out_marker
  );
endinterface

// File: rtl/id_serial_issue.sv
// Decode-to-execute issue register with a serializing-instruction sequencer.
// A serializing instruction (syscall, LL, SC) is issued as a marker, followed by
// BUBBLES empty EXE cycles, then a one-cycle NOTIFY that consumes it from ID and
// raises SYS when the simulator must service it.
// Optional macro ID_PERF_CNT_EN builds the serialize / bubble performance counters.
module id_serial_issue #(
  parameter int PAYLOAD_W = 160,
  parameter int BUBBLES   = 3,
  parameter int CNT_W     = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  id_serial_issue_if.slave     bus,
  input  logic                 flush,
  output logic                 SYS,
  output logic                 WANT_FREEZE,
  output logic [31:0]          perf_serial_cnt,
  output logic [31:0]          perf_bubble_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_NOTIFY = 2'd2;

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic                 out_valid_p0;
  logic                 out_marker_p0;
  logic [PAYLOAD_W-1:0] out_payload_p0;
  logic                 load_en;
  logic                 is_serial;
  logic                 start_drain;

  assign load_en     = !out_valid_p0 || bus.out_ready;
  assign is_serial   = bus.in_valid && bus.in_serialize;
  assign start_drain = (state == S_IDLE) && !flush && load_en && is_serial;

  assign bus.out_valid   = out_valid_p0;
  assign bus.out_marker  = out_marker_p0;
  assign bus.out_payload = out_payload_p0;

  // ID acknowledge, fetch freeze and simulator request from state and inputs
  always_comb begin
    bus.in_ready = 1'b0;
    WANT_FREEZE  = 1'b0;
    SYS          = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!flush) begin
          if (is_serial) WANT_FREEZE  = 1'b1;
          else           bus.in_ready = load_en;
        end
      end
      S_DRAIN: WANT_FREEZE = !flush;
      S_NOTIFY: begin
        // SYS is already committed here, so a same-cycle flush does not cancel it
        bus.in_ready = !flush;
        SYS          = bus.in_notify && bus.in_serialize;
      end
      default: ;
    endcase
  end

  // ---- stage p0: issue slot, sequencer state and bubble counter ----
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= S_IDLE;
      cnt            <= '0;
      out_valid_p0   <= 1'b0;
      out_marker_p0  <= 1'b0;
      out_payload_p0 <= '0;
    end else if (flush) begin
      state         <= S_IDLE;
      cnt           <= '0;
      out_valid_p0  <= 1'b0;
      out_marker_p0 <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_en) begin
            if (bus.in_valid) begin
              out_payload_p0 <= bus.in_payload;
              out_valid_p0   <= 1'b1;
              out_marker_p0  <= bus.in_serialize;
              if (bus.in_serialize) begin
                cnt   <= CNT_W'(BUBBLES);
                state <= S_DRAIN;
              end
            end else begin
              out_valid_p0  <= 1'b0;
              out_marker_p0 <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // the marker leaves through the normal handshake; only empty cycles count
          if (out_valid_p0) begin
            if (bus.out_ready) begin
              out_valid_p0  <= 1'b0;
              out_marker_p0 <= 1'b0;
            end
          end else if (cnt <= CNT_W'(1)) begin
            cnt   <= '0;
            state <= S_NOTIFY;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_NOTIFY: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

`ifdef ID_PERF_CNT_EN
  logic [31:0] serial_cnt;
  logic [31:0] bubble_cnt;

  // event counters; flush does not reset them, they wrap naturally
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      serial_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (start_drain) serial_cnt <= serial_cnt + 32'd1;
      if ((state == S_DRAIN) && !out_valid_p0) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign perf_serial_cnt = serial_cnt;
  assign perf_bubble_cnt = bubble_cnt;
`else
  logic unused_perf;
  assign unused_perf     = start_drain;
  assign perf_serial_cnt = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_serial_issue.sv
// Self-checking bench for id_serial_issue: directed serialize scenarios plus a
// randomized normal-instruction stream, against a slot/timeline model.
module tb_id_serial_issue;
  localparam int PW = 64;
  localparam int B  = 3;
  localparam int L  = 3 + B;   // cycles from presenting a serializer to its NOTIFY, inclusive

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic sys;
  logic want_freeze;
  logic [31:0] perf_serial;
  logic [31:0] perf_bubble;

  int checks = 0;
  int errors = 0;
  int m_serial = 0;
  int m_bubble = 0;

  logic [4:0]    tr_bits [64];
  logic [PW-1:0] tr_pl   [64];

  id_serial_issue_if #(.PAYLOAD_W(PW)) bus ();

  id_serial_issue #(.PAYLOAD_W(PW), .BUBBLES(B), .CNT_W(4)) dut (
    .CLK             (clk),
    .RESET           (rst_n),
    .bus             (bus),
    .flush           (flush),
    .SYS             (sys),
    .WANT_FREEZE     (want_freeze),
    .perf_serial_cnt (perf_serial),
    .perf_bubble_cnt (perf_bubble)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [PW-1:0] rnd_pl();
    return {$urandom(), $urandom()};
  endfunction

  // Expected {out_valid, out_marker, WANT_FREEZE, in_ready, SYS} at cycle rel
  // after a serializer is presented to an empty IDLE register, marker stalled s cycles.
  function automatic logic [4:0] expect_bits(int rel, int s, logic nt);
    logic ov, wf, ir;
    ov = (rel >= 1) && (rel <= 1 + s);
    wf = (rel >= 0) && (rel <= 1 + s + B);
    ir = (rel == 2 + s + B);
    return {ov, ov, wf, ir, ir & nt};
  endfunction

  function automatic logic [31:0] perf_exp(int v);
`ifdef ID_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  task automatic idle_inputs();
    bus.in_valid     = 1'b0;
    bus.in_serialize = 1'b0;
    bus.in_notify    = 1'b0;
    bus.in_payload   = '0;
    bus.out_ready    = 1'b1;
    flush            = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    idle_inputs();
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Drives one or more serializing instructions and records the outputs each cycle.
  task automatic record(input logic [PW-1:0] p1, input logic [PW-1:0] p2, input int sw,
                        input logic nt, input int stall, input int fl, input int n);
    for (int k = 0; k < n; k++) begin
      bus.in_valid     = (fl < 0) || (k <= fl);
      bus.in_serialize = bus.in_valid;
      bus.in_notify    = nt & bus.in_valid;
      bus.in_payload   = (k >= sw) ? p2 : p1;
      bus.out_ready    = !((k >= 1) && (k <= stall));
      flush            = (k == fl);
      @(negedge clk);
      tr_bits[k] = {bus.out_valid, bus.out_marker, want_freeze, bus.in_ready, sys};
      tr_pl[k]   = bus.out_payload;
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_marker, sys, want_freeze} !== 4'b0 || bus.out_payload !== '0)
      $display("FAIL reset_hold: got v=%b m=%b sys=%b wf=%b pl=%h, exp all 0",
               bus.out_valid, bus.out_marker, sys, want_freeze, bus.out_payload);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready, want_freeze, sys} !== 4'b0100 ||
        perf_serial !== 32'd0 || perf_bubble !== 32'd0) begin
      errors++;
      $display("FAIL reset_release: got v=%b rdy=%b wf=%b sys=%b ps=%0d pb=%0d, exp 0100 0 0",
               bus.out_valid, bus.in_ready, want_freeze, sys, perf_serial, perf_bubble);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    logic [PW-1:0] p [4];
    logic [4:0] got, exp;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        p[k] = rnd_pl();
        bus.in_valid = 1'b1; bus.in_payload = p[k];
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      got = {bus.out_valid, bus.out_marker, want_freeze, bus.in_ready, sys};
      exp = {(k >= 1 && k <= 4), 1'b0, 1'b0, 1'b1, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stream_ctrl cyc %0d: got %b exp %b", k, got, exp);
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if (bus.out_payload !== p[k-1]) begin
          errors++;
          $display("FAIL stream_payload cyc %0d: got %h exp %h", k, bus.out_payload, p[k-1]);
        end
      end
      @(posedge clk); #1;
    end
    idle_cycles(1);
  endtask

  // Shared comparison of a recorded single-serializer trace against the timeline model.
  task automatic test_serial(input string name, input logic nt, input int stall);
    logic [PW-1:0] p;
    logic [4:0] exp;
    p = rnd_pl();
    record(p, p, 99, nt, stall, -1, L + stall);
    m_serial += 1;
    m_bubble += B;
    for (int k = 0; k < L + stall; k++) begin
      exp = expect_bits(k, stall, nt);
      checks++;
      if (tr_bits[k] !== exp) begin
        errors++;
        $display("FAIL %s cyc %0d: got %b exp %b", name, k, tr_bits[k], exp);
      end
      if (exp[4]) begin
        checks++;
        if (tr_pl[k] !== p) begin
          errors++;
          $display("FAIL %s_payload cyc %0d: got %h exp %h", name, k, tr_pl[k], p);
        end
      end
    end
    checks++;
    if (perf_serial !== perf_exp(m_serial) || perf_bubble !== perf_exp(m_bubble)) begin
      errors++;
      $display("FAIL %s_perf: got %0d/%0d exp %0d/%0d", name, perf_serial, perf_bubble,
               perf_exp(m_serial), perf_exp(m_bubble));
    end
    idle_cycles(1);
  endtask

  task automatic test_syscall();
    test_serial("syscall", 1'b1, 0);
  endtask

  task automatic test_ll();
    test_serial("ll", 1'b0, 0);
  endtask

  task automatic test_stall();
    test_serial("stall", 1'b1, 2);
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] p1, p2;
    logic [4:0] exp;
    int pulses;
    p1 = rnd_pl(); p2 = rnd_pl();
    record(p1, p2, L, 1'b1, 0, -1, 2 * L);
    m_serial += 2;
    m_bubble += 2 * B;
    pulses = 0;
    for (int k = 0; k < 2 * L; k++) begin
      exp = expect_bits((k < L) ? k : k - L, 0, 1'b1);
      pulses += int'(tr_bits[k][0]);
      checks++;
      if (tr_bits[k] !== exp) begin
        errors++;
        $display("FAIL b2b cyc %0d: got %b exp %b", k, tr_bits[k], exp);
      end
      if (exp[4]) begin
        checks++;
        if (tr_pl[k] !== ((k < L) ? p1 : p2)) begin
          errors++;
          $display("FAIL b2b_payload cyc %0d: got %h exp %h", k, tr_pl[k], (k < L) ? p1 : p2);
        end
      end
    end
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("FAIL b2b_sys_pulses: got %0d exp 2", pulses);
    end
    idle_cycles(1);
  endtask

  task automatic test_flush();
    logic [PW-1:0] p;
    logic [4:0] exp;
    p = rnd_pl();
    record(p, p, 99, 1'b1, 0, 2, 7);
    m_serial += 1;
    m_bubble += 1;
    for (int k = 0; k < 7; k++) begin
      if (k < 2)       exp = expect_bits(k, 0, 1'b1);
      else if (k == 2) exp = 5'b00000;
      else             exp = 5'b00010;
      checks++;
      if (tr_bits[k] !== exp) begin
        errors++;
        $display("FAIL flush cyc %0d: got %b exp %b", k, tr_bits[k], exp);
      end
    end
    checks++;
    if (perf_serial !== perf_exp(m_serial) || perf_bubble !== perf_exp(m_bubble)) begin
      errors++;
      $display("FAIL flush_perf: got %0d/%0d exp %0d/%0d", perf_serial, perf_bubble,
               perf_exp(m_serial), perf_exp(m_bubble));
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_drain();
    bus.in_valid = 1'b1; bus.in_serialize = 1'b1; bus.in_notify = 1'b1;
    bus.in_payload = rnd_pl(); bus.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    m_serial = 0;
    m_bubble = 0;
    checks++;
    if ({bus.out_valid, bus.out_marker, sys, want_freeze} !== 4'b0 || bus.out_payload !== '0 ||
        perf_serial !== 32'd0 || perf_bubble !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_drain: got v=%b m=%b sys=%b wf=%b pl=%h ps=%0d pb=%0d, exp all 0",
               bus.out_valid, bus.out_marker, sys, want_freeze, bus.out_payload,
               perf_serial, perf_bubble);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({bus.out_valid, sys, want_freeze, bus.in_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL after_reset cyc %0d: got %b exp 0001", k,
                 {bus.out_valid, sys, want_freeze, bus.in_ready});
      end
    end
    @(posedge clk); #1;
  endtask

  // Random normal traffic against a one-slot buffer model; notify alone must be ignored.
  task automatic test_random();
    logic          m_valid;
    logic [PW-1:0] m_pl;
    logic          exp_rdy;
    m_valid = 1'b0;
    m_pl    = '0;
    for (int k = 0; k < 300; k++) begin
      bus.in_valid     = $urandom_range(0, 1) == 1;
      bus.in_serialize = 1'b0;
      bus.in_notify    = $urandom_range(0, 1) == 1;
      bus.in_payload   = rnd_pl();
      bus.out_ready    = $urandom_range(0, 3) != 0;
      flush            = $urandom_range(0, 15) == 0;
      exp_rdy = !flush && (!m_valid || bus.out_ready);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== m_valid || (m_valid && bus.out_payload !== m_pl) ||
          bus.in_ready !== exp_rdy || sys !== 1'b0 || want_freeze !== 1'b0 ||
          bus.out_marker !== 1'b0) begin
        errors++;
        $display("FAIL random cyc %0d: got v=%b pl=%h rdy=%b sys=%b wf=%b mk=%b exp v=%b pl=%h rdy=%b 0 0 0",
                 k, bus.out_valid, bus.out_payload, bus.in_ready, sys, want_freeze,
                 bus.out_marker, m_valid, m_pl, exp_rdy);
      end
      if (flush) m_valid = 1'b0;
      else if (!m_valid || bus.out_ready) begin
        m_valid = bus.in_valid;
        if (bus.in_valid) m_pl = bus.in_payload;
      end
      @(posedge clk); #1;
    end
    idle_cycles(2);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_stream();
    test_syscall();
    test_ll();
    test_stall();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
